// File: rtl/clk_step_ctrl_if.sv
// Board-facing bundle for clk_step_ctrl: switch and pushbutton inputs,
// processor clock/strobe outputs, LED and state visibility.
interface clk_step_ctrl_if #(
    parameter int LED_W = 4
);
    logic             mode_slow;  // async switch: 0 = fast tap, 1 = slow tap
    logic             run;        // async switch: 1 = free-run, 0 = halt / step
    logic             step_n;     // raw pushbutton, active-low, bouncy
    logic             divclock;   // registered processor clock
    logic             clk_en;     // one-cycle strobe on every divclock rise
    logic [LED_W-1:0] LEDR;       // counter MSBs
    logic [1:0]       state_o;    // 00 HALT, 01 RUN, 10 STEP_HI, 11 STEP_LO

    // Board / bench side: drives switches and button, observes the outputs.
    modport master (
        output mode_slow, run, step_n,
        input  divclock, clk_en, LEDR, state_o
    );

    // Controller side.
    modport slave (
        input  mode_slow, run, step_n,
        output divclock, clk_en, LEDR, state_o
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// Processor clock controller for board bring-up. A free-running counter
// feeds the LEDs and supplies two divclock taps (fast / slow). The core
// clock can free-run, halt, or advance one step per debounced button press.
// clk_en is a one-cycle strobe that coincides with every divclock rise.
module clk_step_ctrl #(
    parameter int CNT_W       = 28,
    parameter int FAST_BIT    = 5,
    parameter int SLOW_BIT    = 22,
    parameter int LED_W       = 4,
    parameter int DBNC_CYCLES = 1000000,
    parameter int DBNC_W      = 20,
    parameter int STEP_LEN    = 32
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    clk_step_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_HALT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_STEP_HI = 2'b10,
        ST_STEP_LO = 2'b11
    } state_t;

    localparam int                STEP_W    = $clog2(STEP_LEN + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_LEN - 1);
    localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CYCLES - 1);

    // Free-running counter
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Two-stage synchronisers: [0] first stage, [1] synchronised output
    logic [1:0]        mode_sync_q;
    logic [1:0]        run_sync_q;
    logic [1:0]        step_sync_q;
    logic              mode_slow_s;
    logic              run_s;
    logic              step_s;

    // Debouncer
    logic              stable_q;
    logic              stable_d;
    logic [DBNC_W-1:0] dbnc_cnt_q;
    logic [DBNC_W-1:0] dbnc_cnt_d;
    logic              press;

    // Clock FSM
    state_t            state_q;
    logic              divclock_q;
    logic              clk_en_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic              tap;

    assign count_d     = count_q + CNT_W'(1);
    assign mode_slow_s = mode_sync_q[1];
    assign run_s       = run_sync_q[1];
    assign step_s      = step_sync_q[1];

    // A mode change is seen by the next tap sample; no glitch filtering is
    // needed because divclock is re-registered from the tap.
    assign tap = mode_slow_s ? count_q[SLOW_BIT] : count_q[FAST_BIT];

    // Counter runs in every state and wraps naturally at 2^CNT_W.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Bring the async switches and button into the CLOCK_50 domain.
    // step_n idles high, so its stages reset to 1 to avoid a false press.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            mode_sync_q <= 2'b00;
            run_sync_q  <= 2'b00;
            step_sync_q <= 2'b11;
        end else begin
            mode_sync_q <= {mode_sync_q[0], bus.mode_slow};
            run_sync_q  <= {run_sync_q[0],  bus.run};
            step_sync_q <= {step_sync_q[0], bus.step_n};
        end
    end

    // Debounce next-state: accept a new button level only after it has been
    // held for DBNC_CYCLES consecutive cycles; any return to the accepted
    // level restarts the count. press fires on the cycle stable falls.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves a variable unassigned (which would infer a latch).
    always_comb begin
        dbnc_cnt_d = '0;
        stable_d   = stable_q;
        press      = 1'b0;
        if (step_s != stable_q) begin
            if (dbnc_cnt_q == DBNC_LAST) begin
                stable_d = step_s;
                press    = ~step_s;
            end else begin
                dbnc_cnt_d = dbnc_cnt_q + DBNC_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            stable_q   <= 1'b1;
            dbnc_cnt_q <= '0;
        end else begin
            stable_q   <= stable_d;
            dbnc_cnt_q <= dbnc_cnt_d;
        end
    end

    // Clock FSM with registered divclock / clk_en. Leaving HALT or RUN is
    // only decided while divclock is low, so a high phase is never cut short.
    // A manual step always runs to completion regardless of run_s.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_HALT;
            divclock_q <= 1'b0;
            clk_en_q   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            clk_en_q <= 1'b0;
            unique case (state_q)
                ST_HALT: begin
                    divclock_q <= 1'b0;
                    // run has priority; a press with run_s=1 is dropped.
                    if (run_s) begin
                        if (!tap) begin
                            state_q <= ST_RUN;
                        end
                    end else if (press) begin
                        state_q    <= ST_STEP_HI;
                        divclock_q <= 1'b1;
                        clk_en_q   <= 1'b1;
                        step_cnt_q <= '0;
                    end
                end

                ST_RUN: begin
                    divclock_q <= tap;
                    clk_en_q   <= tap & ~divclock_q;
                    if (!run_s && !divclock_q && !tap) begin
                        state_q <= ST_HALT;
                    end
                end

                ST_STEP_HI: begin
                    if (step_cnt_q == STEP_LAST) begin
                        state_q    <= ST_STEP_LO;
                        divclock_q <= 1'b0;
                        step_cnt_q <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end

                ST_STEP_LO: begin
                    divclock_q <= 1'b0;
                    if (step_cnt_q == STEP_LAST) begin
                        state_q    <= ST_HALT;
                        step_cnt_q <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end

                default: begin
                    state_q    <= ST_HALT;
                    divclock_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.divclock = divclock_q;
    assign bus.clk_en   = clk_en_q;
    assign bus.LEDR     = count_q[CNT_W-1 -: LED_W];
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl (DBNC_CYCLES=16, STEP_LEN=8). A second,
// narrow-counter instance (CNT_W=8) exercises the counter wrap and LED MSBs.
module tb_clk_step_ctrl;

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_SHI  = 2'b10;
    localparam logic [1:0] S_SLO  = 2'b11;

    logic clk;
    logic reset_n;

    int errors = 0;
    int checks = 0;

    // Per-cycle activity seen by tick()
    int   n_clken, n_hi, n_sthi, n_stlo, n_viol;
    logic prev_div, prev_en, rise;

    clk_step_ctrl_if #(.LED_W(4)) bus   ();
    clk_step_ctrl_if #(.LED_W(4)) bus_w ();

    clk_step_ctrl #(
        .CNT_W(28), .FAST_BIT(5), .SLOW_BIT(22), .LED_W(4),
        .DBNC_CYCLES(16), .DBNC_W(5), .STEP_LEN(8)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    clk_step_ctrl #(
        .CNT_W(8), .FAST_BIT(2), .SLOW_BIT(6), .LED_W(4),
        .DBNC_CYCLES(16), .DBNC_W(5), .STEP_LEN(8)
    ) dut_w (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (bus_w)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance to the next falling edge and record what the outputs did.
    // clk_en must equal a divclock rise, never repeat, never appear in HALT/STEP_LO.
    task automatic tick();
        @(negedge clk);
        rise = bus.divclock & ~prev_div;
        if (bus.clk_en !== rise) n_viol++;
        if (bus.clk_en && prev_en) n_viol++;
        if (bus.clk_en && (bus.state_o == S_HALT || bus.state_o == S_SLO)) n_viol++;
        if (bus.divclock) n_hi++;
        if (bus.clk_en) n_clken++;
        if (bus.state_o == S_SHI) n_sthi++;
        if (bus.state_o == S_SLO) n_stlo++;
        prev_div = bus.divclock;
        prev_en  = bus.clk_en;
    endtask

    task automatic clear_mon();
        n_clken = 0; n_hi = 0; n_sthi = 0; n_stlo = 0;
    endtask

    task automatic wait_rise(input int budget);
        int k = 0;
        tick();
        while (!rise && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        int k = 0;
        while (bus.state_o !== st && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic check_viol(input string name);
        checks++;
        if (n_viol !== 0) begin
            errors++;
            $display("FAIL %s_clk_en_rules: violations=%0d expected 0", name, n_viol);
        end
        n_viol = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.run = 1'b1; bus.mode_slow = 1'b0; bus.step_n = 1'b1;
        bus_w.run = 1'b0; bus_w.mode_slow = 1'b0; bus_w.step_n = 1'b1;
        prev_div = 1'b0; prev_en = 1'b0; n_viol = 0;
        repeat (3) tick();
        checks++;
        if (bus.divclock !== 1'b0) begin errors++; $display("FAIL reset_divclock: got %b expected 0", bus.divclock); end
        checks++;
        if (bus.clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", bus.clk_en); end
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.state_o); end
        checks++;
        if (bus.LEDR !== 4'h0) begin errors++; $display("FAIL reset_ledr: got %h expected 0", bus.LEDR); end
        reset_n = 1'b1;
    endtask

    // run=1, fast tap: 32 high / 32 low, clk_en on each rise.
    task automatic test_run_fast();
        int hi, lo;
        clear_mon();
        wait_state(S_RUN, 10);
        checks++;
        if (bus.state_o !== S_RUN) begin errors++; $display("FAIL run_entry: state=%b expected 01", bus.state_o); end
        wait_rise(100);
        checks++;
        if (bus.clk_en !== 1'b1) begin errors++; $display("FAIL run_first_rise_en: got %b expected 1", bus.clk_en); end
        hi = 1;
        tick();
        while (bus.divclock === 1'b1 && hi < 200) begin hi++; tick(); end
        lo = 1;
        tick();
        while (!rise && lo < 200) begin lo++; tick(); end
        checks++;
        if (hi !== 32) begin errors++; $display("FAIL run_high_len: got %0d expected 32", hi); end
        checks++;
        if (lo !== 32) begin errors++; $display("FAIL run_low_len: got %0d expected 32", lo); end
        checks++;
        if (bus.clk_en !== 1'b1) begin errors++; $display("FAIL run_second_rise_en: got %b expected 1", bus.clk_en); end
        checks++;
        if (n_clken !== 2) begin errors++; $display("FAIL run_en_count: got %0d expected 2", n_clken); end
        checks++;
        if (bus.LEDR !== 4'h0) begin errors++; $display("FAIL run_ledr: got %h expected 0", bus.LEDR); end
        check_viol("run_fast");
    endtask

    // Slow tap: count[22] is 0 this early, so divclock goes and stays low.
    task automatic test_mode_slow();
        bus.mode_slow = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.divclock !== 1'b0) begin errors++; $display("FAIL slow_follow: divclock=%b expected 0", bus.divclock); end
        clear_mon();
        repeat (100) tick();
        checks++;
        if (n_hi !== 0) begin errors++; $display("FAIL slow_hold_low: high cycles=%0d expected 0", n_hi); end
        checks++;
        if (n_clken !== 0) begin errors++; $display("FAIL slow_no_en: clk_en count=%0d expected 0", n_clken); end
        check_viol("mode_slow");
    endtask

    // Drop run during a high phase: it completes, then HALT.
    task automatic test_halt();
        int hi;
        bus.mode_slow = 1'b0;
        wait_rise(200);
        bus.run = 1'b0;
        hi = 1;
        tick();
        while (bus.divclock === 1'b1 && hi < 200) begin hi++; tick(); end
        checks++;
        if (hi !== 32) begin errors++; $display("FAIL halt_high_complete: got %0d expected 32", hi); end
        // HALT is registered at the end of the first low cycle.
        tick();
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL halt_state: got %b expected 00", bus.state_o); end
        clear_mon();
        repeat (100) tick();
        checks++;
        if (n_hi !== 0 || n_clken !== 0) begin
            errors++; $display("FAIL halt_quiet: high=%0d en=%0d expected 0 0", n_hi, n_clken);
        end
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL halt_stays: got %b expected 00", bus.state_o); end
        check_viol("halt");
    endtask

    // Five 3-cycle glitches then a solid press: exactly one 8+8 step.
    task automatic test_step_bounce();
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            bus.step_n = 1'b0; repeat (3) tick();
            bus.step_n = 1'b1; repeat (3) tick();
        end
        bus.step_n = 1'b0;
        repeat (50) tick();
        checks++;
        if (n_clken !== 1) begin errors++; $display("FAIL step_en_count: got %0d expected 1", n_clken); end
        checks++;
        if (n_hi !== 8) begin errors++; $display("FAIL step_high_len: got %0d expected 8", n_hi); end
        checks++;
        if (n_sthi !== 8 || n_stlo !== 8) begin
            errors++; $display("FAIL step_phase_len: hi=%0d lo=%0d expected 8 8", n_sthi, n_stlo);
        end
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL step_return: got %b expected 00", bus.state_o); end
        bus.step_n = 1'b1;
        repeat (30) tick();
        checks++;
        if (n_clken !== 1) begin errors++; $display("FAIL step_release_quiet: en count=%0d expected 1", n_clken); end
        check_viol("step_bounce");
    endtask

    // run rises mid-step: the step completes, HALT, then RUN at tap=0.
    task automatic test_step_run_mid();
        clear_mon();
        bus.step_n = 1'b0;
        wait_state(S_SHI, 40);
        checks++;
        if (bus.state_o !== S_SHI) begin errors++; $display("FAIL mid_step_start: got %b expected 10", bus.state_o); end
        repeat (3) tick();
        bus.run = 1'b1;
        wait_state(S_HALT, 40);
        checks++;
        if (n_sthi !== 8 || n_stlo !== 8) begin
            errors++; $display("FAIL mid_step_complete: hi=%0d lo=%0d expected 8 8", n_sthi, n_stlo);
        end
        checks++;
        if (n_clken !== 1) begin errors++; $display("FAIL mid_step_en: got %0d expected 1", n_clken); end
        wait_state(S_RUN, 80);
        checks++;
        if (bus.state_o !== S_RUN) begin errors++; $display("FAIL mid_run_entry: got %b expected 01", bus.state_o); end
        checks++;
        if (bus.divclock !== 1'b0) begin errors++; $display("FAIL mid_run_low: divclock=%b expected 0", bus.divclock); end
        bus.step_n = 1'b1;
        repeat (25) tick();
        check_viol("step_run_mid");
    endtask

    // Presses in RUN are discarded and not replayed once halted.
    task automatic test_press_discard();
        bus.step_n = 1'b0;
        clear_mon();
        repeat (40) tick();
        checks++;
        if (n_sthi !== 0 || bus.state_o !== S_RUN) begin
            errors++; $display("FAIL run_press_ignored: step cycles=%0d state=%b expected 0 01", n_sthi, bus.state_o);
        end
        bus.run = 1'b0;
        wait_state(S_HALT, 100);
        clear_mon();
        repeat (40) tick();
        checks++;
        if (n_sthi !== 0 || n_clken !== 0) begin
            errors++; $display("FAIL press_not_queued: step=%0d en=%0d expected 0 0", n_sthi, n_clken);
        end
        bus.step_n = 1'b1;
        repeat (25) tick();
        check_viol("press_discard");
    endtask

    // Async reset in STEP_HI clears outputs immediately; quiet afterwards.
    task automatic test_reset_mid();
        bus.step_n = 1'b0;
        wait_state(S_SHI, 40);
        repeat (2) tick();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.divclock !== 1'b0 || bus.clk_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: div=%b en=%b expected 0 0", bus.divclock, bus.clk_en);
        end
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL rst_mid_state: got %b expected 00", bus.state_o); end
        checks++;
        if (dut.count_q !== 28'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", dut.count_q); end
        bus.step_n = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        clear_mon();
        repeat (60) tick();
        checks++;
        if (n_clken !== 0 || n_sthi !== 0) begin
            errors++; $display("FAIL rst_mid_quiet: en=%0d step=%0d expected 0 0", n_clken, n_sthi);
        end
        checks++;
        if (bus.state_o !== S_HALT) begin errors++; $display("FAIL rst_mid_halt: got %b expected 00", bus.state_o); end
        check_viol("reset_mid");
    endtask

    // Counter wrap on the 8-bit instance: count 254,255 -> LEDR F; 256 -> 0.
    task automatic test_wrap();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (254) tick();
        checks++;
        if (bus_w.LEDR !== 4'hF) begin errors++; $display("FAIL wrap_ledr_254: got %h expected f", bus_w.LEDR); end
        tick();
        checks++;
        if (bus_w.LEDR !== 4'hF) begin errors++; $display("FAIL wrap_ledr_255: got %h expected f", bus_w.LEDR); end
        tick();
        checks++;
        if (bus_w.LEDR !== 4'h0) begin errors++; $display("FAIL wrap_ledr_0: got %h expected 0", bus_w.LEDR); end
        checks++;
        if (dut_w.count_q !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", dut_w.count_q); end
        checks++;
        if (bus.LEDR !== 4'h0) begin errors++; $display("FAIL wide_ledr: got %h expected 0", bus.LEDR); end
    endtask

    initial begin
        test_reset();
        test_run_fast();
        test_mode_slow();
        test_halt();
        test_step_bounce();
        test_step_run_mid();
        test_press_discard();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
